// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned SYS_CLK_HZ           = 12_000_000;
  localparam int unsigned BAUD_DEFAULT         = 9600;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = SYS_CLK_HZ / BAUD_DEFAULT;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] ST_WAIT_HIGH = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_CLEANUP   = 3'd5;

  typedef enum logic [2:0] {
    s_WAIT_HIGH = ST_WAIT_HIGH,
    s_IDLE      = ST_IDLE,
    s_START     = ST_START,
    s_DATA      = ST_DATA,
    s_STOP      = ST_STOP,
    s_CLEANUP   = ST_CLEANUP
  } rx_state_t;

  // True for the states that belong to a frame in progress.
  function automatic logic in_frame(rx_state_t s);
    return (s == s_START) || (s == s_DATA) || (s == s_STOP);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and strobes out.
interface uart_rx_if
  import uart_pkg::*;
();

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    input  rx,
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start check, centre sampling, one-cycle strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master rx_if
);

  localparam int unsigned        HALF_BIT    = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0]   HALF_CNT    = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0]   BIT_END     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [1:0]         SYNC_FILLED = 2'd2;

  logic                 rx_s;
  logic [1:0]           sync_fill;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 dv_q, dv_nxt;
  logic                 fe_q, fe_nxt;
  logic                 busy_q, busy_nxt;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_if.rx),
    .q       (rx_s)
  );

  // The synchronizer leaves reset high; rx_s is trusted only once both flops hold real line samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_fill <= 2'd0;
    end else if (sync_fill != SYNC_FILLED) begin
      sync_fill <= sync_fill + 2'd1;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= s_WAIT_HIGH;
      cnt     <= '0;
      idx     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift_q <= shift_nxt;
      data_q  <= data_nxt;
      dv_q    <= dv_nxt;
      fe_q    <= fe_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift_q;
    data_nxt  = data_q;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;

    unique case (state)
      s_WAIT_HIGH: begin
        if (rx_s && (sync_fill == SYNC_FILLED)) begin
          state_nxt = s_IDLE;
        end
      end
      s_IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = '0;
          state_nxt = s_START;
        end
      end
      s_START: begin
        if (cnt == HALF_CNT) begin
          if (!rx_s) begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = s_DATA;
          end else begin
            state_nxt = s_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      s_DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == LAST_IDX) begin
            state_nxt = s_STOP;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      s_STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift_q;
            dv_nxt    = 1'b1;
            state_nxt = s_CLEANUP;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = s_WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      s_CLEANUP: begin
        state_nxt = s_IDLE;
      end
      default: begin
        state_nxt = s_WAIT_HIGH;
      end
    endcase
  end

  // busy covers the edges at which a frame is both in progress and continuing.
  assign busy_nxt = in_frame(state) && in_frame(state_nxt);

  assign rx_if.data        = data_q;
  assign rx_if.data_valid  = dv_q;
  assign rx_if.frame_error = fe_q;
  assign rx_if.busy        = busy_q;

endmodule
